// File: rtl/ps2_rx_reader_if.sv
// Purpose: bundles the PS/2 line samples, writer ownership flag and decoded-byte outputs of the reader.
// Latency: none, signal container only.
// Backpressure: none; strobes are fire-and-forget, busyRead/busyWrite arbitrate bus ownership.
interface ps2_rx_reader_if;
  logic       ps2c;
  logic       ps2d;
  logic       busyWrite;
  logic [7:0] data;
  logic       dataValid;
  logic       parityErr;
  logic       frameErr;
  logic       busyRead;

  // Environment side: drives the wire samples and writer ownership, observes results.
  modport master (
    output ps2c, ps2d, busyWrite,
    input  data, dataValid, parityErr, frameErr, busyRead
  );

  // Reader side.
  modport slave (
    input  ps2c, ps2d, busyWrite,
    output data, dataValid, parityErr, frameErr, busyRead
  );
endinterface

// File: rtl/ps2_rx_reader.sv
// Purpose: decodes device-to-host PS/2 frames into bytes with valid / parity / framing strobes.
// Latency: strobes appear 2 ck cycles after the cycle holding the 11th filtered ps2c fall.
// Backpressure: none; the bus is ignored while busyWrite is high and busyRead flags a frame in flight.
module ps2_rx_reader #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic           ck,
  input logic           reset,
  ps2_rx_reader_if.slave rx_if
);

  localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Two-flop synchronizers for both wire samples.
  logic c_s1_q, c_s2_q;
  logic d_s1_q, d_s2_q;

  // Filtered levels and their stability counters.
  logic          filt_c_q, filt_c_d;
  logic          filt_d_q, filt_d_d;
  logic [FW-1:0] fcnt_c_q, fcnt_c_d;
  logic [FW-1:0] fcnt_d_q, fcnt_d_d;

  // Previous filtered clock level, used to form the one-cycle fall pulse.
  logic prev_c_q;
  logic fall;

  // Frame reception state.
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [10:0]        frame_q, frame_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   tmo_inc;

  // Registered outputs.
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;

  // Synchronize the asynchronous wire samples into the ck domain; idle level of both lines is 1.
  always_ff @(posedge ck) begin
    if (reset) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      c_s1_q <= rx_if.ps2c;
      c_s2_q <= c_s1_q;
      d_s1_q <= rx_if.ps2d;
      d_s2_q <= d_s1_q;
    end
  end

  // Filter: the level only follows the synchronized input once it has disagreed for FILTER_LEN cycles in a row.
  always_comb begin
    filt_c_d = filt_c_q;
    fcnt_c_d = '0;
    filt_d_d = filt_d_q;
    fcnt_d_d = '0;
    if (c_s2_q != filt_c_q) begin
      if (fcnt_c_q == FW'(FILTER_LEN - 1)) begin
        filt_c_d = c_s2_q;
      end else begin
        fcnt_c_d = fcnt_c_q + 1'b1;
      end
    end
    if (d_s2_q != filt_d_q) begin
      if (fcnt_d_q == FW'(FILTER_LEN - 1)) begin
        filt_d_d = d_s2_q;
      end else begin
        fcnt_d_d = fcnt_d_q + 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      filt_c_q <= 1'b1;
      filt_d_q <= 1'b1;
      fcnt_c_q <= '0;
      fcnt_d_q <= '0;
      prev_c_q <= 1'b1;
    end else begin
      filt_c_q <= filt_c_d;
      filt_d_q <= filt_d_d;
      fcnt_c_q <= fcnt_c_d;
      fcnt_d_q <= fcnt_d_d;
      prev_c_q <= filt_c_q;
    end
  end

  // A fall is the single cycle in which the filtered clock has just dropped; ps2d is taken from filt_d_q then.
  assign fall    = prev_c_q & ~filt_c_q;
  // The timeout counter holds the number of cycles since the last fall, counting the fall cycle as 1.
  assign tmo_inc = tmo_q + 1'b1;

  // Next-state and strobe decode for frame reception.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        tmo_d = '0;
        if (fall && !rx_if.busyWrite) begin
          // Bits enter at the top and shift down, so the start bit lands in frame[0] after 11 falls.
          frame_d = {filt_d_q, 10'b0};
          cnt_d   = 4'd1;
          tmo_d   = TMO_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_if.busyWrite) begin
          // Writer took the bus: drop the partial frame silently.
          state_d = IDLE;
          cnt_d   = 4'd0;
          tmo_d   = '0;
        end else if (fall) begin
          frame_d = {filt_d_q, frame_q[10:1]};
          cnt_d   = cnt_q + 4'd1;
          tmo_d   = TMO_W'(1);
          if (cnt_q == 4'd10) begin
            state_d = CHECK;
          end
        end else if (tmo_inc == TMO_W'(TIMEOUT_CYC)) begin
          fe_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        tmo_d   = '0;
        if (!rx_if.busyWrite) begin
          if (frame_q[0] || !frame_q[10]) begin
            fe_d = 1'b1;
          end else if (!(^frame_q[9:1])) begin
            pe_d = 1'b1;
          end else begin
            data_d = frame_q[8:1];
            dv_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        tmo_d   = '0;
      end
    endcase
  end

  // Frame state and output registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      frame_q <= '0;
      tmo_q   <= '0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.dataValid = dv_q;
  assign rx_if.parityErr = pe_q;
  assign rx_if.frameErr  = fe_q;
  assign rx_if.busyRead  = (state_q != IDLE);

endmodule

// File: doc/ps2_rx_reader.md
Name: ps2_rx_reader

Overview:
Receives device-to-host PS/2 frames on the shared PS2_CLK/PS2_DATA lines and presents each byte with a one-cycle valid strobe. It is the read-side companion of the host writer. It raises busyRead while a frame is in progress, so the writer cannot start mid-frame. While busyWrite is high it ignores the bus, so the writer's own clock and data activity is not decoded.

Parameters:
FILTER_LEN, 8, consecutive ck cycles a synchronized line must hold a new level before the filtered level changes.
TIMEOUT_CYC, 100000, ck cycles without a filtered ps2c falling edge before an open frame is aborted (1 ms at 100 MHz).

Ports:
ck  input  1  system clock (100 MHz).
reset  input  1  synchronous, active-high reset.
ps2c  input  1  PS/2 clock line, read-only sample of the open-collector wire.
ps2d  input  1  PS/2 data line, read-only sample.
busyWrite  input  1  host writer owns the bus; reader holds IDLE.
data  output  8  last received byte, LSB = first data bit on the wire.
dataValid  output  1  one-cycle strobe: data updated by a good frame.
parityErr  output  1  one-cycle strobe: frame complete but odd parity wrong.
frameErr  output  1  one-cycle strobe: start bit not 0, stop bit not 1, or timeout.
busyRead  output  1  frame reception in progress.

Behaviour:
- Reset and clocking: the synchronous reset is active-high on ck and is the only clock domain.
  - On reset: data=8'h00, dataValid=0, parityErr=0, frameErr=0, busyRead=0, state=IDLE, bit count=0, timeout counter=0.
  - The filtered ps2c and ps2d levels reset to 1.
- Input conditioning: ps2c and ps2d each pass through a 2-flop synchronizer, then a filter.
  - The filtered level takes a new value only after the synchronized value has differed from it for FILTER_LEN consecutive cycles.
  - A fall is a one-cycle pulse on the cycle the filtered ps2c goes 1->0. ps2d is sampled from its filtered level in that same cycle.
- State machine: IDLE, RECV, CHECK.
  - IDLE: busyRead=0. A fall with busyWrite=0 stores bit 0 (the start bit), sets count=1 and moves to RECV.
  - IDLE with busyWrite=1: falls are ignored and the state stays IDLE.
  - RECV: busyRead=1.
    - Each fall shifts in the filtered ps2d and increments count.
    - When the fall that makes count=11 occurs, go to CHECK on the next cycle.
    - The timeout counter clears on every fall. When it reaches TIMEOUT_CYC, pulse frameErr, discard the frame and go to IDLE.
  - CHECK: busyRead=1, one cycle only, then IDLE. The frame is bit0 = start, bits1..8 = data LSB-first, bit9 = parity, bit10 = stop.
    - If start!=0 or stop!=1: pulse frameErr.
    - Else if the XOR of data and parity is 0 (not odd parity): pulse parityErr.
    - Else: load data and pulse dataValid.
    - All strobes are registered and appear in the cycle after CHECK.
- Latency: dataValid rises exactly 2 ck cycles after the cycle holding the 11th fall pulse. It is high for exactly 1 cycle.
- Output hold: data holds its value until the next good frame. Parity and frame errors do not modify data.
- Strobe exclusivity: at most one of dataValid, parityErr and frameErr is high in any cycle.
- busyWrite rising mid-frame (RECV or CHECK): abort to IDLE next cycle. No strobe is issued and busyRead drops.
- Reset mid-frame: return to IDLE with all outputs at reset values. No strobe is issued for the partial frame.
- Glitches: a ps2c glitch shorter than FILTER_LEN cycles produces no fall and is not counted.
- Back-to-back frames: a fall on the cycle after CHECK is accepted as a new start bit. No gap beyond the IDLE cycle is required.

Test Plan:
1. Valid frame for 0x1C:
   - Stimulus: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1, at 50 µs half-periods.
   - Required: data=8'h1C, dataValid one cycle 2 cycles after the 11th fall; busyRead high from the 1st fall to the CHECK cycle.
2. Bad parity:
   - Stimulus: 0xF0 sent with parity bit 0 instead of the correct 1.
   - Required: parityErr one cycle, no dataValid, data keeps its previous value 8'h1C.
3. Timeout:
   - Stimulus: ps2c stops after 5 falls.
   - Required: frameErr pulses TIMEOUT_CYC cycles after the 5th fall, state returns to IDLE, and a following good 0xAA frame yields data=8'hAA.
4. Writer ownership:
   - Stimulus: busyWrite=1 while 11 falls occur; then busyWrite asserted after the 4th fall of a second frame.
   - Required: no strobes in either case, busyRead=0 while busyWrite is held, and abort to IDLE within 1 cycle.
5. Glitch and stop-bit error:
   - Stimulus: 3-cycle low pulses on ps2c mid-frame, then a frame with stop bit 0.
   - Required: the glitches are ignored and the frame completes correctly; the stop-bit frame gives frameErr only.
6. Reset and back-to-back:
   - Stimulus: synchronous reset asserted after the 7th fall; then two consecutive 0x12 frames.
   - Required: outputs return to reset values with no strobe; afterwards there are two dataValid pulses, each with data=8'h12.
